rate_motor_mixer: RTL
=====================

// Module: rate_motor_mixer
// PURPOSE
//  Consumer end of the rate-controller start/complete handshake. Samples the three
//  signed PID rate outputs plus throttle on a rising start edge, mixes them into four
//  quad-X motor commands, saturates each one, then raises complete_signal for one cycle.
//  Sits between the body-frame rate controller and the PWM/ESC drivers.
// PARAMETERS
//  RATE_W      16   width of signed rate inputs, 12.4 fixed point (PID_RATE_BIT_WIDTH)
//  RATE_SHIFT  4    fractional bits dropped after mixing
//  MOTOR_W     8    width of unsigned motor command outputs and throttle
//  MOTOR_MIN   0    lower saturation bound, in motor units
//  MOTOR_MAX   250  upper saturation bound, in motor units
// PORTS
//  us_clk          in   1        1 MHz system clock
//  reset           in   1        asynchronous, active-high reset
//  start_signal    in   1        level from the rate controller's complete_signal
//  armed           in   1        0 forces all motor outputs to 0
//  throttle        in   MOTOR_W  unsigned base thrust, in motor units
//  yaw_rate_in     in   RATE_W   signed yaw correction, 12.4
//  roll_rate_in    in   RATE_W   signed roll correction, 12.4
//  pitch_rate_in   in   RATE_W   signed pitch correction, 12.4
//  motor_fl        out  MOTOR_W  front-left command (motor index 0)
//  motor_fr        out  MOTOR_W  front-right command (motor index 1)
//  motor_rr        out  MOTOR_W  rear-right command (motor index 2)
//  motor_rl        out  MOTOR_W  rear-left command (motor index 3)
//  complete_signal out  1        one-cycle pulse when new motor values are valid
//  overrun         out  1        one-cycle pulse when a start edge arrives while busy
// BEHAVIOUR
//  - Reset (asynchronous, any state): all motor_* = 0, complete_signal = 0, overrun = 0,
//    state = WAITING, index = 0, start_signal history register = 0, latches and staging = 0.
//  - Start edge: start_signal == 1 and its value registered on the previous clock == 0.
//  - States (one-hot): WAITING, CALC, COMPLETE.
//  - WAITING: on a start edge at clock edge E0, latch all inputs, set index = 0, go to CALC.
//  - CALC: on edges E1..E4, compute motor[index] into staging and increment index.
//    After index 3 (edge E4), go to COMPLETE.
//  - COMPLETE: on edge E5, copy staging to motor_* (all four together, never partially),
//    pulse complete_signal high for exactly the cycle after E5, go to WAITING.
//  - Latency: start edge sampled at E0 -> outputs and complete_signal valid after E5.
//    A new start is accepted on the cycle after the pulse.
//  - Mix, with T = {0, throttle} << RATE_SHIFT, sign-extended to RATE_W+3 bits, and
//    P/R/Y = the latched, sign-extended rates:
//      FL = T + P + R - Y
//      FR = T + P - R + Y
//      RR = T - P - R - Y
//      RL = T - P + R + Y
//  - Result = sum >>> RATE_SHIFT (arithmetic shift, truncate toward negative infinity),
//    then clamped to [MOTOR_MIN, MOTOR_MAX]. The sum width of RATE_W+3 bits never overflows.
//  - Start edge while in CALC or COMPLETE: ignored (no re-latch), overrun pulses for one
//    cycle, the cycle in progress finishes using the original latched inputs.
//  - start_signal held high: counts as one edge only; no retrigger until it falls and rises.
//  - armed == 0 at E5: motor_* are written as 0 and complete_signal still pulses.
//    armed falling in any state: motor_* = 0 on the next edge. The FSM is unaffected.
//  - Reset during CALC: the cycle is aborted, no complete_signal pulse; a fresh start
//    edge after reset is processed normally.
// STRUCTURE
//  - common_defines.v: MOTOR_BIT_WIDTH, MOTOR_MIN, MOTOR_MAX, motor index localparams
//    (FL=0, FR=1, RR=2, RL=3), per-motor P/R/Y sign table, state encodings.
//  - Sub-module motor_sat_clamp: combinational shift plus saturate from RATE_W+3 bits to
//    MOTOR_W bits. It is instantiated once and shared across the four CALC cycles.
// TESTING
//  1. throttle=100, all rates=0, armed=1, start edge -> all motors=100;
//     complete_signal high exactly 1 cycle, 5 edges after the latch edge.
//  2. throttle=100, pitch=16'h00A0 (+10.0) -> FL=FR=110, RR=RL=90.
//  3. throttle=245, roll=16'h0140 (+20.0) -> FL=250 (265 clamped), FR=225, RR=225,
//     RL=250 (clamped).
//  4. throttle=5, yaw=16'h00A0 (+10.0) -> FL=0 (-5 clamped), FR=15, RR=0, RL=15.
//  5. Second start edge 2 cycles into CALC with new inputs -> overrun pulses 1 cycle;
//     outputs reflect the first inputs; only one complete_signal pulse.
//  6. reset asserted at CALC index 2 -> motors=0 and no pulse; after release, case 1
//     stimulus -> all motors=100. Also armed=0 with case 1 stimulus -> motors=0 and
//     complete_signal still pulses.

Source files
------------

// File: rtl/rate_motor_mixer_pkg.sv
// Shared widths, saturation bounds, motor ordering and the quad-X sign table
// for the rate-to-motor mixer.
package rate_motor_mixer_pkg;

  localparam int RATE_W     = 16;
  localparam int RATE_SHIFT = 4;
  localparam int MOTOR_W    = 8;
  localparam int MOTOR_MIN  = 0;
  localparam int MOTOR_MAX  = 250;
  localparam int SUM_W      = RATE_W + 3;
  localparam int N_MOTORS   = 4;

  localparam int IDX_FL = 0;
  localparam int IDX_FR = 1;
  localparam int IDX_RR = 2;
  localparam int IDX_RL = 3;

  typedef logic [1:0] motor_idx_t;

  // Per motor {pitch, roll, yaw} negate flags; element 0 is FL.
  localparam logic [N_MOTORS-1:0][2:0] NEG_PRY = {3'b100, 3'b111, 3'b010, 3'b001};

  typedef enum logic [2:0] {
    ST_WAITING  = 3'b001,
    ST_CALC     = 3'b010,
    ST_COMPLETE = 3'b100
  } state_t;

  function automatic logic signed [SUM_W-1:0] apply_sign(
    input logic signed [SUM_W-1:0] value,
    input logic                    neg
  );
    return neg ? -value : value;
  endfunction

endpackage

// File: rtl/rate_motor_mixer_if.sv
// Rate controller / motor mixer handshake and data bundle. The master drives
// the rates and start level; the slave (the mixer) returns motor commands.
interface rate_motor_mixer_if;
  import rate_motor_mixer_pkg::*;

  logic                      start_signal;
  logic                      armed;
  logic        [MOTOR_W-1:0] throttle;
  logic signed [RATE_W-1:0]  yaw_rate_in;
  logic signed [RATE_W-1:0]  roll_rate_in;
  logic signed [RATE_W-1:0]  pitch_rate_in;
  logic        [MOTOR_W-1:0] motor_fl;
  logic        [MOTOR_W-1:0] motor_fr;
  logic        [MOTOR_W-1:0] motor_rr;
  logic        [MOTOR_W-1:0] motor_rl;
  logic                      complete_signal;
  logic                      overrun;

  modport master (
    output start_signal, armed, throttle, yaw_rate_in, roll_rate_in, pitch_rate_in,
    input  motor_fl, motor_fr, motor_rr, motor_rl, complete_signal, overrun
  );

  modport slave (
    input  start_signal, armed, throttle, yaw_rate_in, roll_rate_in, pitch_rate_in,
    output motor_fl, motor_fr, motor_rr, motor_rl, complete_signal, overrun
  );

endinterface

// File: rtl/rate_motor_mixer_motor_sat_clamp.sv
// Drops the fractional bits of a mixed sum (floor) and saturates the result
// into the motor command range.
module motor_sat_clamp
  import rate_motor_mixer_pkg::*;
(
  input  logic signed [SUM_W-1:0]   sum,
  output logic        [MOTOR_W-1:0] motor
);

  localparam logic signed [SUM_W-1:0] LO = SUM_W'(MOTOR_MIN);
  localparam logic signed [SUM_W-1:0] HI = SUM_W'(MOTOR_MAX);

  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    shifted = sum >>> RATE_SHIFT;
    if (shifted < LO) begin
      motor = MOTOR_W'(MOTOR_MIN);
    end else if (shifted > HI) begin
      motor = MOTOR_W'(MOTOR_MAX);
    end else begin
      motor = shifted[MOTOR_W-1:0];
    end
  end

endmodule

// File: rtl/rate_motor_mixer.sv
// Latches rates on a start edge, mixes one motor per cycle through a shared
// clamp, then publishes all four commands together with a completion pulse.
//   state       | meaning
//   WAITING     | idle, watching for a start edge
//   CALC        | one motor per cycle into staging (index 0..3)
//   COMPLETE    | staging -> motor outputs, complete pulse follows
module rate_motor_mixer
  import rate_motor_mixer_pkg::*;
(
  input  logic               us_clk,
  input  logic               reset,
  rate_motor_mixer_if.slave  bus
);

  state_t state, state_next;

  logic                                 start_prev;
  logic                                 start_edge;
  motor_idx_t                           index;
  logic        [MOTOR_W-1:0]            throttle_q;
  logic signed [RATE_W-1:0]             yaw_q, roll_q, pitch_q;
  logic        [N_MOTORS-1:0][MOTOR_W-1:0] staging;
  logic        [N_MOTORS-1:0][MOTOR_W-1:0] motor_q;
  logic                                 complete_q, overrun_q;

  logic latch_en, calc_en, publish, overrun_set;

  logic signed [SUM_W-1:0] t_ext, p_ext, r_ext, y_ext, sum;
  logic        [2:0]       neg;
  logic        [MOTOR_W-1:0] clamped;

  assign start_edge = bus.start_signal & ~start_prev;

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state <= ST_WAITING;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    latch_en    = 1'b0;
    calc_en     = 1'b0;
    publish     = 1'b0;
    overrun_set = 1'b0;
    case (state)
      ST_WAITING: begin
        if (start_edge) begin
          latch_en   = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        calc_en     = 1'b1;
        overrun_set = start_edge;
        if (index == 2'd3) begin
          state_next = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        publish     = 1'b1;
        overrun_set = start_edge;
        state_next  = ST_WAITING;
      end
      default: state_next = ST_WAITING;
    endcase
  end

  // Throttle is lifted into the same 12.4 scale as the rates before mixing.
  always_comb begin
    t_ext = {{(SUM_W-MOTOR_W){1'b0}}, throttle_q} << RATE_SHIFT;
    p_ext = {{(SUM_W-RATE_W){pitch_q[RATE_W-1]}}, pitch_q};
    r_ext = {{(SUM_W-RATE_W){roll_q[RATE_W-1]}}, roll_q};
    y_ext = {{(SUM_W-RATE_W){yaw_q[RATE_W-1]}}, yaw_q};
    neg   = NEG_PRY[index];
    sum   = t_ext + apply_sign(p_ext, neg[2]) + apply_sign(r_ext, neg[1])
                  + apply_sign(y_ext, neg[0]);
  end

  motor_sat_clamp u_clamp (
    .sum   (sum),
    .motor (clamped)
  );

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b0;
      index      <= '0;
      throttle_q <= '0;
      yaw_q      <= '0;
      roll_q     <= '0;
      pitch_q    <= '0;
      staging    <= '0;
      motor_q    <= '0;
      complete_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      start_prev <= bus.start_signal;
      complete_q <= publish;
      overrun_q  <= overrun_set;
      if (latch_en) begin
        throttle_q <= bus.throttle;
        yaw_q      <= bus.yaw_rate_in;
        roll_q     <= bus.roll_rate_in;
        pitch_q    <= bus.pitch_rate_in;
        index      <= '0;
      end
      if (calc_en) begin
        staging[index] <= clamped;
        index          <= index + 2'd1;
      end
      // Disarm wins immediately; otherwise outputs only change as a full set.
      if (!bus.armed) begin
        motor_q <= '0;
      end else if (publish) begin
        motor_q <= staging;
      end
    end
  end

  assign bus.motor_fl        = motor_q[IDX_FL];
  assign bus.motor_fr        = motor_q[IDX_FR];
  assign bus.motor_rr        = motor_q[IDX_RR];
  assign bus.motor_rl        = motor_q[IDX_RL];
  assign bus.complete_signal = complete_q;
  assign bus.overrun         = overrun_q;

endmodule
